// File: rtl/run_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// run_ctrl_pkg
//
// Definitions shared by the run controller and its sub-module.
//
// Contents:
//   run_state_e      - controller state encoding. The same 2-bit value is
//                      presented on the mode output, so external tools can
//                      decode it with these names.
//   run_is_active()  - true for the states in which instructions may advance
//                      (STEP and CONT). The controller uses it to detect entry
//                      into an executing state.
// ---------------------------------------------------------------------------
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN_HALT = 2'd0,
        RUN_STEP = 2'd1,
        RUN_CONT = 2'd2,
        RUN_BRK  = 2'd3
    } run_state_e;

    function automatic logic run_is_active(input run_state_e s);
        return (s == RUN_STEP) || (s == RUN_CONT);
    endfunction

endpackage

// File: rtl/edge_det.sv
// ---------------------------------------------------------------------------
// edge_det
//
// Rising-edge detector built on a one-flop history register. The history
// register is cleared by a synchronous reset, so a level that is already high
// when reset is released reports one edge on the first cycle after reset.
//
// Ports:
//   clk   in   system clock, rising edge active
//   rst   in   synchronous active-high reset, clears the history register
//   din   in   level to watch
//   rise  out  high in every cycle where din=1 and din was 0 on the previous
//              cycle. Combinational from din and the registered history.
// ---------------------------------------------------------------------------
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic din_d;

    always_comb begin
        din_d = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/run_ctrl.sv
// ---------------------------------------------------------------------------
// run_ctrl
//
// Run controller for a multi-cycle processor. It decides cycle by cycle
// whether the control FSM and the datapath registers may advance (run). It
// supports halting, single-stepping one instruction, continuous running, and
// stopping on a breakpoint address.
//
// An instruction boundary is a fetch cycle reached after the current run
// session has already fetched at least once. Every decision to stop happens
// on a boundary. Run is dropped in that cycle, so the fetch is held until
// execution resumes.
//
// Parameters:
//   WIDTH       width of pc, brk_addr and both counters
//
// Ports:
//   clk         in   system clock, rising edge active
//   rst         in   synchronous active-high reset; forces run=0 while high
//   cont        in   continuous-run request (level)
//   step        in   single-step request (debounced level, edge-detected)
//   fetch       in   control FSM is in its fetch state this cycle
//   pc          in   address of the instruction fetched while fetch=1
//   brk_en      in   breakpoint enable
//   brk_addr    in   breakpoint address
//   run         out  advance enable (combinational, never depends on step)
//   mode        out  registered copy of the controller state (run_state_e)
//   brk_hit     out  registered, high while stopped on a breakpoint
//   cycle_cnt   out  cycles with run=1, wraps modulo 2^WIDTH
//   instr_cnt   out  cycles with run=1 and fetch=1, wraps modulo 2^WIDTH
// ---------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cont,
    input  logic             step,
    input  logic             fetch,
    input  logic [WIDTH-1:0] pc,
    input  logic             brk_en,
    input  logic [WIDTH-1:0] brk_addr,
    output logic             run,
    output logic [1:0]       mode,
    output logic             brk_hit,
    output logic [WIDTH-1:0] cycle_cnt,
    output logic [WIDTH-1:0] instr_cnt
);

    // -----------------------------------------------------------------------
    // Request edge detection
    // -----------------------------------------------------------------------
    logic step_rise;
    logic cont_rise;

    edge_det u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (step),
        .rise (step_rise)
    );

    // Leaving BRK needs a fresh cont edge. A cont level still held from
    // before the breakpoint must not restart execution.
    edge_det u_cont_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (cont),
        .rise (cont_rise)
    );

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    run_state_e       state_q,     state_d;
    logic             fetched_q,   fetched_d;
    logic [WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [WIDTH-1:0] instr_cnt_q, instr_cnt_d;
    logic [1:0]       mode_q,      mode_d;
    logic             brk_hit_q,   brk_hit_d;

    logic run_c;
    logic boundary;
    logic bp_match;
    logic entering;

    // -----------------------------------------------------------------------
    // Next-state and run decision
    // -----------------------------------------------------------------------
    always_comb begin
        // fetched is cleared on entry to STEP/CONT. The first fetch of a
        // session is therefore never a boundary, so a breakpoint that stopped
        // execution at a PC cannot fire again on that same PC when resuming.
        boundary = fetch & fetched_q;

        // brk_en and brk_addr matter only on the boundary cycle. Changes in
        // the middle of an instruction have no effect until then.
        bp_match = brk_en & (pc == brk_addr);

        run_c   = 1'b0;
        state_d = state_q;

        case (state_q)
            RUN_HALT: begin
                if (cont) begin
                    state_d = RUN_CONT;
                end else if (step_rise) begin
                    state_d = RUN_STEP;
                end
            end
            RUN_STEP: begin
                // A step edge seen here is consumed and dropped.
                if (boundary) begin
                    state_d = RUN_HALT;
                end else begin
                    run_c = 1'b1;
                end
            end
            RUN_CONT: begin
                if (boundary && bp_match) begin
                    state_d = RUN_BRK;
                end else if (boundary && !cont) begin
                    state_d = RUN_HALT;
                end else begin
                    run_c = 1'b1;
                end
            end
            RUN_BRK: begin
                if (cont_rise) begin
                    state_d = RUN_CONT;
                end else if (step_rise) begin
                    state_d = RUN_STEP;
                end
            end
            default: begin
                state_d = RUN_HALT;
            end
        endcase

        // Reset overrides everything in the same cycle, so nothing advances
        // while it is held.
        if (rst) begin
            run_c = 1'b0;
        end

        entering = run_is_active(state_d) && !run_is_active(state_q);

        fetched_d = fetched_q;
        if (entering) begin
            fetched_d = 1'b0;
        end else if (run_c && fetch) begin
            fetched_d = 1'b1;
        end

        cycle_cnt_d = cycle_cnt_q + {{(WIDTH-1){1'b0}}, run_c};
        instr_cnt_d = instr_cnt_q + {{(WIDTH-1){1'b0}}, (run_c & fetch)};

        mode_d    = state_d;
        brk_hit_d = (state_d == RUN_BRK);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN_HALT;
            fetched_q   <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            mode_q      <= RUN_HALT;
            brk_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetched_q   <= fetched_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            mode_q      <= mode_d;
            brk_hit_q   <= brk_hit_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign run       = run_c;
    assign mode      = mode_q;
    assign brk_hit   = brk_hit_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_ctrl
//
// Bench for run_ctrl with WIDTH=8, so the counters wrap within a short run.
// A stub control FSM idles until run is first seen. After that it runs
// instructions of a fixed 4 cycles, or of random 1..4 cycles, and raises
// fetch on the first cycle of each. The PC starts at 0 and grows by 4 per
// instruction. A behavioural model is checked on every falling edge, and
// directed scenarios pin it with literal values.
// ---------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int W = 8;

    localparam logic [1:0] M_HALT = 2'd0;
    localparam logic [1:0] M_STEP = 2'd1;
    localparam logic [1:0] M_CONT = 2'd2;
    localparam logic [1:0] M_BRK  = 2'd3;

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cont = 1'b0;
    logic         step = 1'b0;
    logic         fetch;
    logic [W-1:0] pc = '0;
    logic         brk_en = 1'b0;
    logic [W-1:0] brk_addr = '0;
    logic         run;
    logic [1:0]   mode;
    logic         brk_hit;
    logic [W-1:0] cycle_cnt;
    logic [W-1:0] instr_cnt;

    always #5 clk = ~clk;

    run_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cont      (cont),
        .step      (step),
        .fetch     (fetch),
        .pc        (pc),
        .brk_en    (brk_en),
        .brk_addr  (brk_addr),
        .run       (run),
        .mode      (mode),
        .brk_hit   (brk_hit),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    // ---------------- control FSM stub ----------------
    int st_phase = -1;   // -1 = idle, otherwise cycle index inside instruction
    int st_len   = 4;
    bit rand_len = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            st_phase <= -1;
            pc       <= '0;
        end else if (run) begin
            if (st_phase < 0) begin
                st_phase <= 0;
                st_len   <= rand_len ? int'($urandom_range(1, 4)) : 4;
            end else if (st_phase == st_len - 1) begin
                st_phase <= 0;
                pc       <= pc + W'(4);
                st_len   <= rand_len ? int'($urandom_range(1, 4)) : 4;
            end else begin
                st_phase <= st_phase + 1;
            end
        end
    end

    assign fetch = (st_phase == 0);

    // ---------------- scoreboard bookkeeping ----------------
    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model follows the rules of the run controller: a session is a
    // stretch of STEP or CONT, and a boundary is any fetch after the
    // session's first one.
    logic [1:0]   m_mode    = M_HALT;
    bit           m_seen    = 1'b0;  // session has fetched at least once
    bit           m_step_p  = 1'b0;
    bit           m_cont_p  = 1'b0;
    logic [W-1:0] m_cyc     = '0;
    logic [W-1:0] m_ins     = '0;
    bit           m_valid   = 1'b0;

    always @(negedge clk) begin
        bit         e_run;
        logic [1:0] nxt;
        bit         bnd;
        bit         s_edge;
        bit         c_edge;
        e_run  = 1'b0;
        nxt    = m_mode;
        bnd    = fetch && m_seen;
        s_edge = step && !m_step_p;
        c_edge = cont && !m_cont_p;

        if (!rst) begin
            if (m_mode == M_HALT) begin
                nxt = cont ? M_CONT : (s_edge ? M_STEP : M_HALT);
            end else if (m_mode == M_STEP) begin
                if (bnd) nxt = M_HALT; else e_run = 1'b1;
            end else if (m_mode == M_CONT) begin
                if (bnd && brk_en && pc == brk_addr) nxt = M_BRK;
                else if (bnd && !cont) nxt = M_HALT;
                else e_run = 1'b1;
            end else begin
                nxt = c_edge ? M_CONT : (s_edge ? M_STEP : M_BRK);
            end
        end

        if (m_valid) begin
            chk("run", 32'(run), 32'(e_run));
            chk("mode", 32'(mode), 32'(m_mode));
            chk("brk_hit", 32'(brk_hit), 32'(m_mode == M_BRK));
            chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
            chk("instr_cnt", 32'(instr_cnt), 32'(m_ins));
        end

        if (rst) begin
            m_mode   = M_HALT;
            m_seen   = 1'b0;
            m_step_p = 1'b0;
            m_cont_p = 1'b0;
            m_cyc    = '0;
            m_ins    = '0;
            m_valid  = 1'b1;
        end else begin
            if (e_run) m_cyc = m_cyc + W'(1);
            if (e_run && fetch) m_ins = m_ins + W'(1);
            if ((nxt == M_STEP || nxt == M_CONT) && !(m_mode == M_STEP || m_mode == M_CONT))
                m_seen = 1'b0;
            else if (e_run && fetch)
                m_seen = 1'b1;
            m_mode   = nxt;
            m_step_p = step;
            m_cont_p = cont;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst      = 1'b1;
        cont     = 1'b0;
        step     = 1'b0;
        brk_en   = 1'b0;
        brk_addr = '0;
        rand_len = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mode", 32'(mode), 32'(M_HALT));
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_cyc", 32'(cycle_cnt), 32'd0);
        chk("rst_ins", 32'(instr_cnt), 32'd0);
        tick();
    endtask

    task automatic wait_mode(input logic [1:0] want, input int budget, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mode === want) begin
                hit = 1'b1;
                break;
            end
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int runs;

        // Single step: IDLE cycle plus one 4-cycle instruction.
        do_reset();
        step = 1'b1;
        runs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (run) runs++;
        end
        chk("step_runs", 32'(runs), 32'd5);
        chk("step_mode", 32'(mode), 32'(M_HALT));
        chk("step_ins", 32'(instr_cnt), 32'd1);
        chk("step_cyc", 32'(cycle_cnt), 32'd5);
        tick();
        step = 1'b0;

        // Continuous run released mid-instruction.
        do_reset();
        cont = 1'b1;
        repeat (20) tick();
        cont = 1'b0;
        wait_mode(M_HALT, 20, "cont_stop_wait");
        chk("cont_ins", 32'(instr_cnt), 32'd5);
        chk("cont_cyc", 32'(cycle_cnt), 32'd21);

        // Breakpoint at 0x0C, then resume past it.
        do_reset();
        brk_en   = 1'b1;
        brk_addr = 8'h0C;
        cont     = 1'b1;
        wait_mode(M_BRK, 40, "brk_wait");
        chk("brk_hit", 32'(brk_hit), 32'd1);
        chk("brk_run", 32'(run), 32'd0);
        chk("brk_ins", 32'(instr_cnt), 32'd3);
        chk("brk_cyc", 32'(cycle_cnt), 32'd13);
        repeat (10) tick();
        @(negedge clk);
        chk("brk_hold", 32'(mode), 32'(M_BRK));
        tick();
        cont = 1'b0;
        tick();
        cont = 1'b1;
        tick();
        cont = 1'b0;
        wait_mode(M_HALT, 20, "resume_wait");
        chk("resume_ins", 32'(instr_cnt), 32'd4);
        chk("resume_cyc", 32'(cycle_cnt), 32'd17);
        brk_en = 1'b0;

        // step and cont together in HALT, then reset mid-CONT.
        do_reset();
        step = 1'b1;
        cont = 1'b1;
        @(negedge clk);
        chk("both_halt", 32'(mode), 32'(M_HALT));
        tick();
        @(negedge clk);
        chk("both_cont", 32'(mode), 32'(M_CONT));
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_run_low", 32'(run), 32'd0);
        tick();
        @(negedge clk);
        chk("abort_mode", 32'(mode), 32'(M_HALT));
        chk("abort_run", 32'(run), 32'd0);
        chk("abort_cyc", 32'(cycle_cnt), 32'd0);
        chk("abort_ins", 32'(instr_cnt), 32'd0);
        tick();
        rst  = 1'b0;
        step = 1'b0;
        cont = 1'b0;

        // Long CONT run: cycle_cnt wraps after 256 run cycles.
        do_reset();
        cont = 1'b1;
        repeat (257) tick();
        @(negedge clk);
        chk("wrap_cyc", 32'(cycle_cnt), 32'd0);
        chk("wrap_mode", 32'(mode), 32'(M_CONT));
        tick();
        cont = 1'b0;
        wait_mode(M_HALT, 20, "wrap_stop_wait");

        // Randomized traffic with variable instruction length.
        do_reset();
        rand_len = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) cont = ~cont;
            step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) brk_en = ~brk_en;
            if ($urandom_range(0, 31) == 0) brk_addr = W'(4 * $urandom_range(0, 7));
        end
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
